jesd204b_dll_tx: RTL and testbench

JESD204B_DLL_TX -- requirements
Module: jesd204b_dll_tx

---
 rtl/jesd204b_dll_tx.sv | 138 +++++++++++++
 tb/tb_jesd204b_dll_tx.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jesd204b_dll_tx.sv
// JESD204B transmit data-link layer: CGS, ILAS and DATA (optionally scrambled) lane words.
// Latency: every output is registered; a DATA word appears one cycle after its tx_datain.
// No backpressure: sync_n from the receiver is the only flow control.
module jesd204b_dll_tx #(
  parameter int F        = 4,
  parameter int K        = 32,
  parameter int ILAS_MF  = 4,
  parameter int SCRAMBLE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sync_n,
  input  logic [31:0]  tx_datain,
  input  logic [111:0] cfg_data,
  output logic [31:0]  tx_dataout,
  output logic [3:0]   tx_charisk,
  output logic         link_up
);

  localparam int MF_WORDS = F * K / 4;
  localparam int LW = $clog2(MF_WORDS);
  localparam int MW = (ILAS_MF > 1) ? $clog2(ILAS_MF) : 1;
  localparam logic [LW-1:0] LMFC_LAST = LW'(MF_WORDS - 1);
  localparam logic [MW-1:0] MF_LAST = MW'(ILAS_MF - 1);

  typedef enum logic [1:0] {CGS, ILAS, DATA} state_t;

  state_t          state, state_nxt;
  logic            sync_r;
  logic [LW-1:0]   lmfc_cnt, lmfc_nxt;
  logic            lmfc_wrap;
  logic [MW-1:0]   mf_cnt, mf_nxt;
  logic [14:0]     scr, scr_nxt;
  logic [31:0]     scr_dat, dat_nxt;
  logic [3:0]      k_nxt;

  // lmfc_cnt tracks the word on tx_dataout, so outputs are built from lmfc_nxt.
  assign lmfc_wrap = (lmfc_cnt == LMFC_LAST);
  assign lmfc_nxt  = lmfc_wrap ? '0 : lmfc_cnt + 1'b1;

  // 1+x^14+x^15 self-synchronous scrambler, bit 31 is first in serial order.
  always_comb begin
    logic [14:0] h;
    h       = scr;
    scr_dat = '0;
    for (int i = 31; i >= 0; i--) begin
      scr_dat[i] = tx_datain[i] ^ h[13] ^ h[14];
      h          = {h[13:0], scr_dat[i]};
    end
    scr_nxt = h;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= CGS;
    else     state <= state_nxt;
  end

  always_comb begin
    int          n;
    logic [7:0]  oct;
    logic        kb;
    logic [111:0] cfg_sh;
    n         = 0;
    oct       = '0;
    kb        = 1'b0;
    cfg_sh    = '0;
    state_nxt = state;
    mf_nxt    = mf_cnt;
    dat_nxt   = 32'hBCBC_BCBC;
    k_nxt     = 4'hF;

    case (state)
      CGS: begin
        mf_nxt = '0;
        if (sync_r && lmfc_wrap) state_nxt = ILAS;
      end
      ILAS: begin
        // Loss of sync wins over ILAS completion.
        if (!sync_r) begin
          state_nxt = CGS;
        end else if (lmfc_wrap) begin
          if (mf_cnt == MF_LAST) state_nxt = DATA;
          else                   mf_nxt = mf_cnt + 1'b1;
        end
      end
      default: begin
        if (!sync_r) state_nxt = CGS;
      end
    endcase

    if (state_nxt == DATA) begin
      dat_nxt = (SCRAMBLE != 0) ? scr_dat : tx_datain;
      k_nxt   = 4'h0;
    end else if (state_nxt == ILAS) begin
      for (int i = 0; i < 4; i++) begin
        n   = int'(lmfc_nxt) * 4 + i;
        oct = n[7:0];
        kb  = 1'b0;
        if (n == 0) begin
          oct = 8'h1C;
          kb  = 1'b1;
        end else if (n == F * K - 1) begin
          oct = 8'h7C;
          kb  = 1'b1;
        end else if (mf_nxt == MW'(1) && n == 1) begin
          oct = 8'h9C;
          kb  = 1'b1;
        end else if (mf_nxt == MW'(1) && n >= 2 && n <= 15) begin
          cfg_sh = cfg_data << (8 * (n - 2));
          oct    = cfg_sh[111:104];
        end
        dat_nxt[8*(3-i) +: 8] = oct;
        k_nxt[3-i]            = kb;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r     <= 1'b0;
      lmfc_cnt   <= '0;
      mf_cnt     <= '0;
      scr        <= '0;
      tx_dataout <= 32'hBCBC_BCBC;
      tx_charisk <= 4'hF;
      link_up    <= 1'b0;
    end else begin
      sync_r     <= sync_n;
      lmfc_cnt   <= lmfc_nxt;
      mf_cnt     <= mf_nxt;
      scr        <= (state_nxt == DATA) ? scr_nxt : '0;
      tx_dataout <= dat_nxt;
      tx_charisk <= k_nxt;
      link_up    <= (state_nxt == DATA);
    end
  end

endmodule

// File: tb/tb_jesd204b_dll_tx.sv
// Bench for jesd204b_dll_tx: cycle scoreboard against a behavioural link model,
// ILAS content table and hand-written sync/reset corner sequences.
module tb_jesd204b_dll_tx;

  localparam int F = 4, K = 32, ILAS_MF = 4;
  localparam int MF_W = F * K / 4;
  localparam int NW = ILAS_MF * MF_W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sync_n = 1'b0;
  logic [31:0]  tx_datain = '0;
  logic [111:0] cfg_data = 112'hA55A_4445_4647_4849_4A4B_4C4D_4E4F;
  logic [31:0]  dout, sdout;
  logic [3:0]   k, sk;
  logic         lu, slu;

  jesd204b_dll_tx #(.F(F), .K(K), .ILAS_MF(ILAS_MF), .SCRAMBLE(0)) dut (
    .clk(clk), .rst(rst), .sync_n(sync_n), .tx_datain(tx_datain), .cfg_data(cfg_data),
    .tx_dataout(dout), .tx_charisk(k), .link_up(lu));

  jesd204b_dll_tx #(.F(F), .K(K), .ILAS_MF(ILAS_MF), .SCRAMBLE(1)) dut_s (
    .clk(clk), .rst(rst), .sync_n(sync_n), .tx_datain(tx_datain), .cfg_data(cfg_data),
    .tx_dataout(sdout), .tx_charisk(sk), .link_up(slu));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dat;
    logic [31:0] sdat;
    logic [3:0]  k;
    logic        lu;
    int          st;
    int          lmfc;
    int          mf;
  } exp_t;

  typedef struct {
    int          mf;
    int          w;
    logic [31:0] dat;
    logic [3:0]  k;
  } ilas_vec_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] obs_dat [NW];
  logic [3:0]  obs_k [NW];
  bit          cap_en = 1'b0;
  ilas_vec_t   tbl [10];

  // link model state: 0=CGS 1=ILAS 2=DATA
  int m_st = 0, m_lmfc = 0, m_mf = 0;
  bit m_sync_r = 1'b0;
  bit s_hist[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic void ilas_oct(input int n, input int mf, output logic [7:0] o, output logic kk);
    logic [111:0] tmp;
    o  = 8'(n % 256);
    kk = 1'b0;
    if (n == 0) begin
      o = 8'h1C; kk = 1'b1;
    end else if (n == F * K - 1) begin
      o = 8'h7C; kk = 1'b1;
    end else if (mf == 1 && n == 1) begin
      o = 8'h9C; kk = 1'b1;
    end else if (mf == 1 && n >= 2 && n <= 15) begin
      tmp = cfg_data << (8 * (n - 2));
      o   = tmp[111:104];
    end
  endfunction

  // Expected result of the coming edge, from the inputs now being driven.
  task automatic model_edge(output exp_t e);
    int nst, n;
    bit wrap, d, a, c, s;
    logic [7:0] o;
    logic kk;
    logic [31:0] sd;
    e.dat = 32'hBCBC_BCBC; e.sdat = 32'hBCBC_BCBC; e.k = 4'hF; e.lu = 1'b0;
    if (rst) begin
      m_st = 0; m_lmfc = 0; m_mf = 0; m_sync_r = 1'b0;
      s_hist.delete();
    end else begin
      wrap = (m_lmfc == MF_W - 1);
      nst  = m_st;
      if (m_st == 0) begin
        if (m_sync_r && wrap) begin nst = 1; m_mf = 0; end
      end else if (!m_sync_r) begin
        nst = 0;
      end else if (m_st == 1 && wrap) begin
        if (m_mf == ILAS_MF - 1) nst = 2;
        else m_mf++;
      end
      m_st     = nst;
      m_lmfc   = wrap ? 0 : m_lmfc + 1;
      m_sync_r = sync_n;
      if (m_st == 1) begin
        e.dat = '0; e.k = '0;
        for (int i = 0; i < 4; i++) begin
          n = 4 * m_lmfc + i;
          ilas_oct(n, m_mf, o, kk);
          e.dat = {e.dat[23:0], o};
          e.k   = {e.k[2:0], kk};
        end
        e.sdat = e.dat;
      end else if (m_st == 2) begin
        e.dat = tx_datain; e.k = 4'h0; e.lu = 1'b1;
        sd = '0;
        for (int b = 31; b >= 0; b--) begin
          d = tx_datain[b];
          a = (s_hist.size() >= 14) ? s_hist[s_hist.size() - 14] : 1'b0;
          c = (s_hist.size() >= 15) ? s_hist[s_hist.size() - 15] : 1'b0;
          s = d ^ a ^ c;
          s_hist.push_back(s);
          if (s_hist.size() > 15) void'(s_hist.pop_front());
          sd = {sd[30:0], s};
        end
        e.sdat = sd;
      end
      if (m_st != 2) s_hist.delete();
    end
    e.st = m_st; e.lmfc = m_lmfc; e.mf = m_mf;
  endtask

  task automatic step();
    exp_t e;
    model_edge(e);
    sb_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("sb_dat", dout, mon_e.dat);
      chk("sb_k", 32'(k), 32'(mon_e.k));
      chk("sb_link_up", 32'(lu), 32'(mon_e.lu));
      chk("sb_scr_dat", sdout, mon_e.sdat);
      chk("sb_scr_k", 32'(sk), 32'(mon_e.k));
      chk("sb_scr_link_up", 32'(slu), 32'(mon_e.lu));
      if (cap_en && mon_e.st == 1) begin
        obs_dat[mon_e.mf * MF_W + mon_e.lmfc] = dout;
        obs_k[mon_e.mf * MF_W + mon_e.lmfc]   = k;
      end
    end
  end

  task automatic wait_lmfc(input int v);
    int t = 0;
    while (m_lmfc != v && t < 2 * MF_W) begin tx_datain = $urandom; step(); t++; end
    chk("wait_lmfc", 32'(m_lmfc), 32'(v));
  endtask

  task automatic wait_ilas(input string nm, input int exp_steps);
    int t = 0;
    while (m_st != 1 && t < 3 * MF_W) begin tx_datain = $urandom; step(); t++; end
    chk(nm, 32'(t), 32'(exp_steps));
    chk({nm, "_lmfc"}, 32'(dut.lmfc_cnt), 32'd0);
    chk({nm, "_dat"}, dout, 32'h1C01_0203);
    chk({nm, "_k"}, 32'(k), 32'h8);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    tbl[0] = '{0, 0,  32'h1C01_0203, 4'b1000};
    tbl[1] = '{0, 5,  32'h1415_1617, 4'b0000};
    tbl[2] = '{0, 31, 32'h7C7D_7E7C, 4'b0001};
    tbl[3] = '{1, 0,  32'h1C9C_A55A, 4'b1100};
    tbl[4] = '{1, 1,  32'h4445_4647, 4'b0000};
    tbl[5] = '{1, 2,  32'h4849_4A4B, 4'b0000};
    tbl[6] = '{1, 3,  32'h4C4D_4E4F, 4'b0000};
    tbl[7] = '{1, 4,  32'h1011_1213, 4'b0000};
    tbl[8] = '{2, 0,  32'h1C01_0203, 4'b1000};
    tbl[9] = '{3, 31, 32'h7C7D_7E7C, 4'b0001};
    for (int i = 0; i < NW; i++) begin obs_dat[i] = 32'hDEAD_BEEF; obs_k[i] = 4'h5; end

    rst = 1'b1; sync_n = 1'b0;
    repeat (3) step();
    chk("rst_dat", dout, 32'hBCBC_BCBC);
    chk("rst_k", 32'(k), 32'hF);
    chk("rst_link_up", 32'(lu), 32'd0);
    chk("rst_lmfc", 32'(dut.lmfc_cnt), 32'd0);

    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tx_datain = $urandom;
      step();
      if (dout !== 32'hBCBC_BCBC || k !== 4'hF || lu !== 1'b0) bad++;
    end
    chk("cgs_hold_100", 32'(bad), 32'd0);

    // sync raised off the LMFC boundary: CGS must hold until the wrap
    wait_lmfc(5);
    cap_en = 1'b1;
    sync_n = 1'b1;
    wait_ilas("ilas1_start", 27);
    repeat (NW - 1) begin tx_datain = $urandom; step(); end
    tx_datain = 32'h1234_5678;
    step();
    cap_en = 1'b0;
    chk("data1_dat", dout, 32'h1234_5678);
    chk("data1_k", 32'(k), 32'h0);
    chk("data1_link_up", 32'(lu), 32'd1);
    chk("data1_lmfc", 32'(dut.lmfc_cnt), 32'd0);

    foreach (tbl[i]) begin
      chk($sformatf("ilas_mf%0d_w%0d_dat", tbl[i].mf, tbl[i].w), obs_dat[tbl[i].mf * MF_W + tbl[i].w], tbl[i].dat);
      chk($sformatf("ilas_mf%0d_w%0d_k", tbl[i].mf, tbl[i].w), 32'(obs_k[tbl[i].mf * MF_W + tbl[i].w]), 32'(tbl[i].k));
    end

    repeat (40) begin tx_datain = $urandom; step(); end

    // sync dropped in DATA: one more data word, then CGS
    sync_n = 1'b0;
    step();
    chk("drop_e1_link_up", 32'(lu), 32'd1);
    step();
    chk("drop_e2_dat", dout, 32'hBCBC_BCBC);
    chk("drop_e2_k", 32'(k), 32'hF);
    chk("drop_e2_link_up", 32'(lu), 32'd0);

    wait_lmfc(20);
    sync_n = 1'b1;
    wait_ilas("ilas2_start", 12);
    repeat (NW - 2) begin tx_datain = $urandom; step(); end
    // sync lost just before ILAS completes: CGS wins over DATA
    sync_n = 1'b0;
    step();
    chk("abort_last_ilas", dout, 32'h7C7D_7E7C);
    step();
    chk("abort_dat", dout, 32'hBCBC_BCBC);
    chk("abort_link_up", 32'(lu), 32'd0);

    sync_n = 1'b1;
    wait_ilas("ilas3_start", 32);
    repeat (NW - 1) begin tx_datain = $urandom; step(); end
    tx_datain = 32'h8000_0000;
    step();
    chk("scr_first_dat", sdout, 32'h8003_000A);
    chk("plain_first_dat", dout, 32'h8000_0000);
    repeat (20) begin tx_datain = $urandom; step(); end

    rst = 1'b1;
    step();
    chk("rst_data_dat", dout, 32'hBCBC_BCBC);
    chk("rst_data_link_up", 32'(lu), 32'd0);
    rst = 1'b0;
    wait_ilas("ilas4_start", 32);
    repeat (40) begin tx_datain = $urandom; step(); end
    rst = 1'b1;
    step();
    chk("rst_ilas_dat", dout, 32'hBCBC_BCBC);
    chk("rst_ilas_k", 32'(k), 32'hF);
    chk("rst_ilas_lmfc", 32'(dut.lmfc_cnt), 32'd0);
    rst = 1'b0;
    sync_n = 1'b0;
    repeat (5) step();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
